ram_tester: RTL and testbench



---
 rtl/ram_tester.sv | 125 ++++++++++++
 tb/tb_ram_tester.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ram_tester.sv
// March self-test engine for a 32x32 single-port synchronous RAM.
// Two passes (pattern, then inverse pattern); reports error count and first failure.
module ram_tester #(
    parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ram_ena,
    output logic        ram_wena,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_count,
    output logic [4:0]  first_err_addr,
    output logic        first_err_pass
);

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, CMPL} state_t;

    state_t      state, state_nxt;
    logic [4:0]  addr_cnt;
    logic        cmp_vld_p1;
    logic [4:0]  cmp_addr_p1;
    logic        cmp_pass_p1;
    logic        mismatch;
    logic [5:0]  err_nxt;

    function automatic logic [31:0] pattern(input logic [4:0] a, input logic inv);
        logic [31:0] p;
        p = SEED ^ {4{3'b000, a}};
        return inv ? ~p : p;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_ena   = 1'b0;
        ram_wena  = 1'b0;
        ram_wdata = '0;
        case (state)
            IDLE: if (start) state_nxt = W0;
            W0: begin
                ram_ena   = 1'b1;
                ram_wena  = 1'b1;
                ram_wdata = pattern(addr_cnt, 1'b0);
                if (addr_cnt == 5'd31) state_nxt = R0;
            end
            R0: begin
                ram_ena = 1'b1;
                if (addr_cnt == 5'd31) state_nxt = W1;
            end
            W1: begin
                ram_ena   = 1'b1;
                ram_wena  = 1'b1;
                ram_wdata = pattern(addr_cnt, 1'b1);
                if (addr_cnt == 5'd31) state_nxt = R1;
            end
            R1: begin
                ram_ena = 1'b1;
                if (addr_cnt == 5'd31) state_nxt = CMPL;
            end
            CMPL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_addr = addr_cnt;
    assign busy     = (state != IDLE);

    // Read data lags the issue edge by one cycle; compare against the registered read tag.
    assign mismatch = cmp_vld_p1 && (ram_rdata != pattern(cmp_addr_p1, cmp_pass_p1));
    assign err_nxt  = mismatch ? sat_inc(err_count) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt       <= '0;
            cmp_vld_p1     <= 1'b0;
            cmp_addr_p1    <= '0;
            cmp_pass_p1    <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_pass <= 1'b0;
        end else begin
            cmp_vld_p1  <= (state == R0) || (state == R1);
            cmp_addr_p1 <= addr_cnt;
            cmp_pass_p1 <= (state == R1);
            if (state inside {W0, R0, W1, R1})
                addr_cnt <= addr_cnt + 5'd1;
            if (state == IDLE) begin
                if (start) begin
                    done           <= 1'b0;
                    pass           <= 1'b0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    first_err_pass <= 1'b0;
                end
            end else begin
                err_count <= err_nxt;
                if (mismatch && (err_count == 6'd0)) begin
                    first_err_addr <= cmp_addr_p1;
                    first_err_pass <= cmp_pass_p1;
                end
                if (state == CMPL) begin
                    done <= 1'b1;
                    pass <= (err_nxt == 6'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_tester.sv
// Directed bench for ram_tester with a behavioural RAM that can inject read faults.
module tb_ram_tester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ram_ena, ram_wena;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        busy, done, pass;
    logic [5:0]  err_count;
    logic [4:0]  first_err_addr;
    logic        first_err_pass;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0 clean, 1 bit0 stuck-at-0, 2 corrupt addr31 pass-1 read, 3 reads return 0

    logic [31:0] mem [32];

    always #5 clk = ~clk;

    ram_tester dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_pass(first_err_pass)
    );

    // ~P(31) = ~(A5A55A5A ^ 1F1F1F1F) = 4545BABA marks the pass-1 contents of addr 31
    always @(posedge clk) begin : ram_model
        logic [31:0] d;
        if (ram_ena) begin
            if (ram_wena) mem[ram_addr] <= ram_wdata;
            else begin
                d = mem[ram_addr];
                if (mode == 1) d = d & 32'hFFFF_FFFE;
                if (mode == 2 && ram_addr == 5'd31 && d == 32'h4545_BABA) d = d ^ 32'h1;
                if (mode == 3) d = '0;
                ram_rdata <= d;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_full(input int m, input bit extra_starts, input logic [5:0] exp_err,
                            input logic [4:0] exp_fa, input logic exp_fp, input logic exp_pass);
        int done_cyc;
        done_cyc = 0;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 135; c++) begin
            @(negedge clk);
            start = extra_starts && (c == 10 || c == 100);
            if (c == 1) begin
                chk("busy_c1", busy, 1'b1);
                chk("done_c1", done, 1'b0);
            end
            if (c == 4 && m == 0) begin
                chk("addr_c4", ram_addr, 5'd3);
                chk("wdata_c4", ram_wdata, 32'hA6A6_5959);
            end
            if (c == 40 && m == 0) begin
                chk("wena_r0", ram_wena, 1'b0);
                chk("wdata_r0", ram_wdata, 32'h0);
            end
            if (c == 68 && m == 0) chk("wdata_c68", ram_wdata, 32'h5959_A6A6);
            if (c == 129) begin
                chk("ena_cmpl", ram_ena, 1'b0);
                chk("busy_cmpl", busy, 1'b1);
            end
            if (done && done_cyc == 0) done_cyc = c;
        end
        chk("done_cycle", done_cyc, 130);
        chk("busy_end", busy, 1'b0);
        chk("pass", pass, exp_pass);
        chk("err_count", err_count, exp_err);
        chk("first_err_addr", first_err_addr, exp_fa);
        chk("first_err_pass", first_err_pass, exp_fp);
    endtask

    initial begin
        int ena_seen;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ena", ram_ena, 1'b0);
        chk("rst_err", err_count, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ena", ram_ena, 1'b0);

        run_full(0, 1'b0, 6'd0,  5'd0,  1'b0, 1'b1);
        run_full(1, 1'b0, 6'd32, 5'd1,  1'b0, 1'b0);
        run_full(2, 1'b0, 6'd1,  5'd31, 1'b1, 1'b0);
        run_full(3, 1'b0, 6'd63, 5'd0,  1'b0, 1'b0);
        run_full(0, 1'b1, 6'd0,  5'd0,  1'b0, 1'b1);

        // Abort mid-R0 with reads failing so error state is non-zero before reset
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_err", err_count, 6'd16);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_ena", ram_ena, 1'b0);
        chk("async_wdata", ram_wdata, 32'h0);
        chk("async_addr", ram_addr, 5'd0);
        chk("async_err", err_count, 6'd0);
        chk("async_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ena_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ram_ena) ena_seen++;
        end
        chk("post_rst_ena", ena_seen, 0);

        run_full(0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
